// File: rtl/cpu_types_pkg.sv
// Shared CPU harness types: datapath word, ALU opcode and the operand sequencer states.
package cpu_types_pkg;

    typedef logic [31:0] word_t;
    typedef logic [3:0]  aluop_t;

    typedef enum logic [1:0] {
        CAP_A  = 2'b00,
        CAP_B  = 2'b01,
        CAP_OP = 2'b10,
        ISSUE  = 2'b11
    } seq_state_t;

endpackage

// File: rtl/alu_key_debounce.sv
// Push-button front end: 2-flop synchronizer, optional debouncer and registered press pulse.
// Define ALU_SEQ_DEBOUNCE_EN for the full debouncer; otherwise the synchronized level is used directly.
module alu_key_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_param
        $error("alu_key_debounce: DEBOUNCE_CYCLES must be at least 2");
    end

    logic       sync1_q, sync1_d;
    logic       sync2_q, sync2_d;
    logic       prev_q, prev_d;
    logic       pulse_q, pulse_d;
    logic       armed_q, armed_d;
    logic [1:0] settle_q, settle_d;
    logic       level;

`ifdef ALU_SEQ_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (sync2_q == acc_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            acc_d = sync2_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= 1'b1;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

    assign level = acc_q;
`else
    assign level = sync2_q;
`endif

    // Pulses are only armed once the synchronizer has flushed and shown the key released,
    // so a key held through reset release cannot fire.
    always_comb begin
        sync1_d  = key_n;
        sync2_d  = sync1_q;
        settle_d = (settle_q == 2'd2) ? settle_q : settle_q + 2'd1;
        armed_d  = armed_q | ((settle_q == 2'd2) & sync2_q);
        prev_d   = level;
        pulse_d  = armed_q & prev_q & ~level;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            prev_q   <= 1'b1;
            pulse_q  <= 1'b0;
            armed_q  <= 1'b0;
            settle_q <= 2'd0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            prev_q   <= prev_d;
            pulse_q  <= pulse_d;
            armed_q  <= armed_d;
            settle_q <= settle_d;
        end
    end

    assign press = pulse_q;

endmodule

// File: rtl/alu_operand_sequencer.sv
// Three-step operand entry (A, B, opcode) from switches and push-buttons, then a held operand set
// with valid/ready handshake. Debounce depth is enabled by defining ALU_SEQ_DEBOUNCE_EN.
module alu_operand_sequencer
    import cpu_types_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        key_n,
    input  logic        clr_n,
    input  logic [15:0] sw_data,
    input  logic [3:0]  sw_op,
    input  logic        ready,
    output word_t       port_a,
    output word_t       port_b,
    output aluop_t      aluop,
    output logic        valid,
    output logic [1:0]  seq_state,
    output logic [7:0]  issue_cnt
);

    logic enter, abort;

    seq_state_t  state_q, state_d;
    logic [15:0] a_q, a_d, b_q, b_d;
    aluop_t      op_q, op_d;
    logic        valid_q, valid_d;
    logic [7:0]  cnt_q, cnt_d;

    alu_key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
        .clk   (CLK),
        .rst_n (nRST),
        .key_n (key_n),
        .press (enter)
    );

    alu_key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr (
        .clk   (CLK),
        .rst_n (nRST),
        .key_n (clr_n),
        .press (abort)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= CAP_A;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    // Abort takes priority over both enter and ready in every state.
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = CAP_A;
        end else begin
            case (state_q)
                CAP_A:   if (enter) state_d = CAP_B;
                CAP_B:   if (enter) state_d = CAP_OP;
                CAP_OP:  if (enter) state_d = ISSUE;
                ISSUE:   if (ready) state_d = CAP_A;
                default: state_d = CAP_A;
            endcase
        end
    end

    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        if (abort) begin
            a_d     = '0;
            b_d     = '0;
            op_d    = '0;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                CAP_A:  if (enter) a_d = sw_data;
                CAP_B:  if (enter) b_d = sw_data;
                CAP_OP: if (enter) begin
                    op_d    = aluop_t'(sw_op);
                    valid_d = 1'b1;
                end
                ISSUE:  if (ready) begin
                    valid_d = 1'b0;
                    cnt_d   = cnt_q + 8'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        port_a    = {16'h0, a_q};
        port_b    = {16'h0, b_q};
        aluop     = op_q;
        valid     = valid_q;
        seq_state = state_q;
        issue_cnt = cnt_q;
    end

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Self-checking bench for alu_operand_sequencer: vector table, scoreboard of issued operand sets,
// and hand-written abort, glitch, wrap and reset sequences.
module tb_alu_operand_sequencer;
    import cpu_types_pkg::*;

    localparam int DEB        = 4;
    localparam int PRESS_LOW  = 12;
    localparam int PRESS_HIGH = 12;
`ifdef ALU_SEQ_DEBOUNCE_EN
    localparam int ABORT_LAT = 8;
`else
    localparam int ABORT_LAT = 4;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        key_n, clr_n, ready;
    logic [15:0] sw_data;
    logic [3:0]  sw_op;
    word_t       port_a, port_b;
    aluop_t      aluop;
    logic        valid;
    logic [1:0]  seq_state;
    logic [7:0]  issue_cnt;

    int checks = 0;
    int errors = 0;
    logic [7:0] cnt_model = 8'd0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  op;
    } vec_t;

    typedef struct {
        word_t      a;
        word_t      b;
        logic [3:0] op;
    } exp_t;

    vec_t vecs[4];
    exp_t sb[$];

    alu_operand_sequencer #(.DEBOUNCE_CYCLES(DEB)) dut (
        .CLK       (clk),
        .nRST      (rst_n),
        .key_n     (key_n),
        .clr_n     (clr_n),
        .sw_data   (sw_data),
        .sw_op     (sw_op),
        .ready     (ready),
        .port_a    (port_a),
        .port_b    (port_b),
        .aluop     (aluop),
        .valid     (valid),
        .seq_state (seq_state),
        .issue_cnt (issue_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic pressKey();
        key_n = 1'b0;
        repeat (PRESS_LOW) @(negedge clk);
        key_n = 1'b1;
        repeat (PRESS_HIGH) @(negedge clk);
    endtask

    task automatic pressClr();
        clr_n = 1'b0;
        repeat (PRESS_LOW) @(negedge clk);
        clr_n = 1'b1;
        repeat (PRESS_HIGH) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op);
        exp_t e;
        sw_data = a;
        pressKey();
        sw_data = b;
        pressKey();
        sw_op = op;
        e.a  = {16'h0, a};
        e.b  = {16'h0, b};
        e.op = op;
        sb.push_back(e);
        pressKey();
    endtask

    task automatic waitValidAndCompare();
        exp_t e;
        int   n = 0;
        while (valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        e = sb.pop_front();
        if (valid !== 1'b1) begin
            checkOutput("valid_timeout", {31'h0, valid}, 32'h1);
        end else begin
            checkOutput("issue_port_a", port_a, e.a);
            checkOutput("issue_port_b", port_b, e.b);
            checkOutput("issue_aluop", {28'h0, aluop}, {28'h0, e.op});
            checkOutput("issue_state", {30'h0, seq_state}, {30'h0, ISSUE});
        end
    endtask

    task automatic handshake();
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        cnt_model = cnt_model + 8'd1;
        checkOutput("hs_valid_low", {31'h0, valid}, 32'h0);
        checkOutput("hs_state", {30'h0, seq_state}, {30'h0, CAP_A});
        checkOutput("hs_issue_cnt", {24'h0, issue_cnt}, {24'h0, cnt_model});
    endtask

    task automatic checkCleared(input string tag, input logic [7:0] cnt);
        checkOutput({tag, "_port_a"}, port_a, 32'h0);
        checkOutput({tag, "_port_b"}, port_b, 32'h0);
        checkOutput({tag, "_aluop"}, {28'h0, aluop}, 32'h0);
        checkOutput({tag, "_valid"}, {31'h0, valid}, 32'h0);
        checkOutput({tag, "_state"}, {30'h0, seq_state}, {30'h0, CAP_A});
        checkOutput({tag, "_issue_cnt"}, {24'h0, issue_cnt}, {24'h0, cnt});
    endtask

    initial begin
        vecs[0] = '{a: 16'h1234, b: 16'h00FF, op: 4'h2};
        vecs[1] = '{a: 16'hFFFF, b: 16'h0000, op: 4'hF};
        vecs[2] = '{a: 16'h0001, b: 16'h8000, op: 4'h0};
        vecs[3] = '{a: 16'hA5C3, b: 16'h3C5A, op: 4'h9};

        rst_n   = 1'b0;
        key_n   = 1'b1;
        clr_n   = 1'b1;
        ready   = 1'b0;
        sw_data = 16'h0;
        sw_op   = 4'h0;
        repeat (3) @(negedge clk);
        checkCleared("reset", 8'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        checkCleared("post_reset", 8'd0);

        for (int i = 0; i < 4; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].op);
            waitValidAndCompare();
            if (i == 0) begin
                for (int c = 0; c < 10; c++) begin
                    @(negedge clk);
                    checkOutput("hold_valid", {31'h0, valid}, 32'h1);
                end
                sw_data = 16'hDEAD;
                sw_op   = 4'h7;
                pressKey();
                checkOutput("issue_press_a", port_a, 32'h1234);
                checkOutput("issue_press_b", port_b, 32'h00FF);
                checkOutput("issue_press_op", {28'h0, aluop}, 32'h2);
                checkOutput("issue_press_state", {30'h0, seq_state}, {30'h0, ISSUE});
            end
            handshake();
            checkOutput("hold_after_issue_a", port_a, {16'h0, vecs[i].a});
        end

        sw_data = 16'h5A5A;
`ifdef ALU_SEQ_DEBOUNCE_EN
        for (int g = 0; g < 3; g++) begin
            key_n = 1'b0;
            repeat (3) @(negedge clk);
            key_n = 1'b1;
            repeat (3) @(negedge clk);
        end
        repeat (10) @(negedge clk);
        checkOutput("glitch_no_capture", {30'h0, seq_state}, {30'h0, CAP_A});
        checkOutput("glitch_port_a", port_a, {16'h0, vecs[3].a});
`endif
        pressKey();
        checkOutput("single_capture_state", {30'h0, seq_state}, {30'h0, CAP_B});
        checkOutput("single_capture_a", port_a, 32'h5A5A);
        sw_data = 16'h6B6B;
        pressKey();
        checkOutput("cap_op_state", {30'h0, seq_state}, {30'h0, CAP_OP});
        pressClr();
        checkCleared("abort_cap_op", cnt_model);

        applyStimulus(16'h4321, 16'h1111, 4'h5);
        waitValidAndCompare();
        clr_n = 1'b0;
        repeat (ABORT_LAT - 1) @(negedge clk);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        repeat (PRESS_LOW - ABORT_LAT) @(negedge clk);
        clr_n = 1'b1;
        repeat (PRESS_HIGH) @(negedge clk);
        checkCleared("abort_ready", cnt_model);

        sw_data = 16'hABCD;
        key_n = 1'b0;
        clr_n = 1'b0;
        repeat (PRESS_LOW) @(negedge clk);
        key_n = 1'b1;
        clr_n = 1'b1;
        repeat (PRESS_HIGH) @(negedge clk);
        checkCleared("abort_enter", cnt_model);

        while (cnt_model != 8'd0) begin
            applyStimulus(16'(cnt_model), 16'(~cnt_model), cnt_model[3:0]);
            waitValidAndCompare();
            handshake();
        end
        checkOutput("issue_cnt_wrap", {24'h0, issue_cnt}, 32'h0);

        applyStimulus(16'h0F0F, 16'hF0F0, 4'h3);
        waitValidAndCompare();
        handshake();
        sw_data = 16'h7777;
        pressKey();
        checkOutput("mid_cap_b_state", {30'h0, seq_state}, {30'h0, CAP_B});
        rst_n = 1'b0;
        #1;
        checkCleared("async_reset", 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
